// File: rtl/updown_counter_n.sv
// updown_counter_n: parametrised up/down counter with optional Gray-coded output,
// wrap or saturate behaviour at the ends, synchronous clear/load and end-of-range flags.
// The binary state always lives in 0..MODULUS-1; count is re-encoded from the
// next state so both outputs change on the same edge.
module updown_counter_n #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned MODULUS  = 2 ** WIDTH,
    parameter bit          GRAY     = 1'b0,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             RST,
    input  logic             en,
    input  logic             dir,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bin,
    output logic             tc,
    output logic             wrap,
    output logic             sat
);

    // Highest legal state and a width-matched increment.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] load_clamped;
    logic             at_top;
    logic             at_bot;

    assign at_top = (bin_q == LAST);
    assign at_bot = (bin_q == '0);

    // Out-of-range load values pin to the top of the count range.
    always_comb begin
        load_clamped = load_val;
        if (32'(load_val) >= MODULUS) begin
            load_clamped = LAST;
        end
    end

    // Next-state: clear over load over step over hold.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        sat_d  = sat_q;
        if (clear) begin
            bin_d = '0;
            sat_d = 1'b0;
        end else if (load) begin
            bin_d = load_clamped;
            sat_d = 1'b0;
        end else if (en) begin
            if (dir) begin
                if (!at_top) begin
                    bin_d = bin_q + ONE;
                    sat_d = 1'b0;
                end else if (SATURATE) begin
                    sat_d = 1'b1;
                end else begin
                    bin_d  = '0;
                    wrap_d = 1'b1;
                    sat_d  = 1'b0;
                end
            end else begin
                if (!at_bot) begin
                    bin_d = bin_q - ONE;
                    sat_d = 1'b0;
                end else if (SATURATE) begin
                    sat_d = 1'b1;
                end else begin
                    bin_d  = LAST;
                    wrap_d = 1'b1;
                    sat_d  = 1'b0;
                end
            end
        end
    end

    // Output encoding is taken from the next state so count tracks count_bin.
    always_comb begin
        count_d = bin_d;
        if (GRAY) begin
            count_d = bin_d ^ (bin_d >> 1);
        end
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clock or negedge RST) begin
        if (!RST) begin
            bin_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            sat_q   <= sat_d;
        end
    end

    assign count     = count_q;
    assign count_bin = bin_q;
    assign wrap      = wrap_q;
    assign sat       = sat_q;
    // Combinational; consumers in other blocks should register it.
    assign tc        = en & ((dir & at_top) | (~dir & at_bot));

endmodule

// File: tb/tb_updown_counter_n.sv
// Bench for updown_counter_n: three instances (binary wrap, Gray wrap, saturate
// modulo 5) share one stimulus; a behavioural model is compared every cycle and
// directed literal expectations pin the model.
module tb_updown_counter_n;

    logic       clock = 1'b0;
    logic       RST;
    logic       en, dir, clear, load;
    logic [2:0] load_val;

    logic [2:0] cnt [3];
    logic [2:0] cbin[3];
    logic       tcv [3];
    logic       wrp [3];
    logic       st  [3];

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    updown_counter_n #(.WIDTH(3), .MODULUS(8), .GRAY(1'b0), .SATURATE(1'b0)) u_bin (
        .clock(clock), .RST(RST), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .count(cnt[0]), .count_bin(cbin[0]), .tc(tcv[0]),
        .wrap(wrp[0]), .sat(st[0])
    );

    updown_counter_n #(.WIDTH(3), .MODULUS(8), .GRAY(1'b1), .SATURATE(1'b0)) u_gray (
        .clock(clock), .RST(RST), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .count(cnt[1]), .count_bin(cbin[1]), .tc(tcv[1]),
        .wrap(wrp[1]), .sat(st[1])
    );

    updown_counter_n #(.WIDTH(3), .MODULUS(5), .GRAY(1'b0), .SATURATE(1'b1)) u_sat5 (
        .clock(clock), .RST(RST), .en(en), .dir(dir), .clear(clear), .load(load),
        .load_val(load_val), .count(cnt[2]), .count_bin(cbin[2]), .tc(tcv[2]),
        .wrap(wrp[2]), .sat(st[2])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: integer state per instance.
    typedef struct packed {
        logic [31:0] b;
        logic        w;
        logic        s;
    } mstate_t;

    int      mmod [3] = '{8, 8, 5};
    bit      msatm[3] = '{1'b0, 1'b0, 1'b1};
    bit      mgry [3] = '{1'b0, 1'b1, 1'b0};
    mstate_t mst  [3];

    function automatic mstate_t mnext(input mstate_t cur, input int mod, input bit satm);
        mstate_t r;
        int      t;
        r   = cur;
        r.w = 1'b0;
        if (clear) begin
            r.b = 0;
            r.s = 1'b0;
        end else if (load) begin
            r.b = (int'(load_val) >= mod) ? mod - 1 : int'(load_val);
            r.s = 1'b0;
        end else if (en) begin
            t = dir ? int'(cur.b) + 1 : int'(cur.b) - 1;
            if (t >= 0 && t < mod) begin
                r.b = t;
                r.s = 1'b0;
            end else if (satm) begin
                r.s = 1'b1;
            end else begin
                r.b = dir ? 0 : mod - 1;
                r.w = 1'b1;
                r.s = 1'b0;
            end
        end
        return r;
    endfunction

    // Model state advances on the same edges as the DUTs.
    always @(posedge clock or negedge RST) begin
        for (int i = 0; i < 3; i++) begin
            if (!RST) mst[i] <= '0;
            else      mst[i] <= mnext(mst[i], mmod[i], msatm[i]);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            int b;
            int ec;
            bit etc;
            b   = int'(mst[i].b);
            ec  = mgry[i] ? (b ^ (b >> 1)) : b;
            etc = en && (dir ? (b == mmod[i] - 1) : (b == 0));
            chk($sformatf("model count[%0d]", i), 32'(cnt[i]), ec);
            chk($sformatf("model count_bin[%0d]", i), 32'(cbin[i]), b);
            chk($sformatf("model tc[%0d]", i), 32'(tcv[i]), 32'(etc));
            chk($sformatf("model wrap[%0d]", i), 32'(wrp[i]), 32'(mst[i].w));
            chk($sformatf("model sat[%0d]", i), 32'(st[i]), 32'(mst[i].s));
        end
    end

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    int  e_up  [9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int  e_gry [9] = '{1, 3, 2, 6, 7, 5, 4, 0, 1};
    int  e_sat [9] = '{1, 2, 3, 4, 4, 4, 4, 4, 4};
    int  e_dn  [3] = '{7, 6, 5};
    logic [2:0] prev_g;

    initial begin
        RST      = 1'b0;
        en       = 1'b0;
        dir      = 1'b1;
        clear    = 1'b0;
        load     = 1'b0;
        load_val = 3'd0;

        // Reset state.
        repeat (2) tick;
        chk("rst count_bin", 32'(cbin[0]), 0);
        chk("rst count gray", 32'(cnt[1]), 0);
        chk("rst wrap", 32'(wrp[0]), 0);
        chk("rst sat", 32'(st[2]), 0);
        chk("rst tc en=0", 32'(tcv[0]), 0);
        en  = 1'b1;
        dir = 1'b0;
        #1;
        chk("rst tc en&~dir", 32'(tcv[0]), 1);
        dir = 1'b1;
        RST = 1'b1;

        // Count up nine edges on all three variants.
        prev_g = 3'd0;
        for (int k = 0; k < 9; k++) begin
            tick;
            chk($sformatf("up bin[%0d]", k), 32'(cbin[0]), e_up[k]);
            chk($sformatf("up wrap[%0d]", k), 32'(wrp[0]), (k == 7) ? 1 : 0);
            chk($sformatf("up tc[%0d]", k), 32'(tcv[0]), (e_up[k] == 7) ? 1 : 0);
            chk($sformatf("gray count[%0d]", k), 32'(cnt[1]), e_gry[k]);
            chk($sformatf("gray bin[%0d]", k), 32'(cbin[1]), e_up[k]);
            chk($sformatf("gray onebit[%0d]", k), $countones(cnt[1] ^ prev_g), 1);
            prev_g = cnt[1];
            chk($sformatf("sat5 bin[%0d]", k), 32'(cbin[2]), e_sat[k]);
            chk($sformatf("sat5 sat[%0d]", k), 32'(st[2]), (k >= 4) ? 1 : 0);
            chk($sformatf("sat5 wrap[%0d]", k), 32'(wrp[2]), 0);
        end

        // Direction change leaves saturation on the next enabled edge.
        dir = 1'b0;
        tick;
        chk("sat5 down bin", 32'(cbin[2]), 3);
        chk("sat5 down sat", 32'(st[2]), 0);
        chk("bin down from 1", 32'(cbin[0]), 0);

        // Count down from reset.
        RST = 1'b0;
        #1;
        chk("rst2 bin", 32'(cbin[0]), 0);
        chk("rst2 tc", 32'(tcv[0]), 1);
        tick;
        RST = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("dn bin[%0d]", k), 32'(cbin[0]), e_dn[k]);
            chk($sformatf("dn wrap[%0d]", k), 32'(wrp[0]), (k == 0) ? 1 : 0);
            chk($sformatf("dn sat5 sat[%0d]", k), 32'(st[2]), 1);
        end

        // Priority: load clamp, clear over load, load over step, hold.
        en       = 1'b0;
        load     = 1'b1;
        load_val = 3'd6;
        tick;
        chk("load clamp sat5", 32'(cbin[2]), 4);
        chk("load bin", 32'(cbin[0]), 6);
        chk("load clears sat", 32'(st[2]), 0);
        clear = 1'b1;
        tick;
        chk("clear over load", 32'(cbin[0]), 0);
        chk("clear over load sat5", 32'(cbin[2]), 0);
        clear    = 1'b0;
        load_val = 3'd2;
        en       = 1'b1;
        dir      = 1'b1;
        tick;
        chk("load over en", 32'(cbin[0]), 2);
        chk("load over en sat5", 32'(cbin[2]), 2);
        load = 1'b0;
        en   = 1'b0;
        tick;
        chk("hold", 32'(cbin[0]), 2);

        // Asynchronous reset mid-count.
        clear = 1'b1;
        tick;
        clear = 1'b0;
        en    = 1'b1;
        dir   = 1'b1;
        repeat (5) tick;
        chk("pre-reset bin", 32'(cbin[0]), 5);
        RST = 1'b0;
        #1;
        chk("async bin", 32'(cbin[0]), 0);
        chk("async count", 32'(cnt[0]), 0);
        chk("async gray", 32'(cnt[1]), 0);
        chk("async sat5", 32'(cbin[2]), 0);
        chk("async sat", 32'(st[2]), 0);
        chk("async wrap", 32'(wrp[0]), 0);
        chk("async tc", 32'(tcv[0]), 0);
        tick;
        RST = 1'b1;
        tick;
        chk("resume 1", 32'(cbin[0]), 1);
        tick;
        chk("resume 2", 32'(cbin[0]), 2);

        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
